jtkunio_scr_romslot: RTL

- Responder side of the scroll layer's ROM access interface.
- Accepts 17-bit tile-ROM word addresses from the scroll tile generator and returns 32-bit words with a valid flag (`rom_ok`).
- Fetches each 32-bit word as a 2-beat 16-bit burst from the SDRAM controller over a req/ack/dok handshake, and keeps the last fetched word cached.
- Sits between the scroll layer and the shared SDRAM arbiter.

---
 rtl/jtkunio_scr_romslot_if.sv | 24 ++
 rtl/jtkunio_scr_romslot.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/jtkunio_scr_romslot_if.sv
// Scroll ROM slot bundle: tile-generator request/response and SDRAM burst handshake.
interface jtkunio_scr_romslot_if #(
  parameter int AW = 22
);
  logic          rom_cs;
  logic [16:0]   rom_addr;
  logic [31:0]   rom_data;
  logic          rom_ok;
  logic [AW-1:0] sdram_addr;
  logic          sdram_req;
  logic          sdram_ack;
  logic          sdram_dok;
  logic [15:0]   sdram_din;

  modport slave (
    input  rom_cs, rom_addr, sdram_ack, sdram_dok, sdram_din,
    output rom_data, rom_ok, sdram_addr, sdram_req
  );

  modport master (
    output rom_cs, rom_addr, sdram_ack, sdram_dok, sdram_din,
    input  rom_data, rom_ok, sdram_addr, sdram_req
  );
endinterface

// File: rtl/jtkunio_scr_romslot.sv
// Scroll tile ROM slot: caches the last 32-bit word fetched as a 2-beat SDRAM burst.
// Optional JTKUNIO_ROMSLOT_2WAY_EN keeps two entries with one-bit LRU replacement.
module jtkunio_scr_romslot #(
  parameter int            AW     = 22,
  parameter logic [AW-1:0] OFFSET = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  jtkunio_scr_romslot_if.slave   bus
);
  // state | meaning
  // IDLE  | serving hits, waiting for a miss
  // REQ   | sdram_req held until arbiter ack
  // BEAT0 | waiting for low half-word
  // BEAT1 | waiting for high half-word, then fill
  typedef enum logic [1:0] {IDLE, REQ, BEAT0, BEAT1} state_t;

  state_t        state_q, state_d;
  logic [15:0]   pend_q, pend_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          req_q, req_d;
  logic          start_fill, lo_we, hi_we;
  logic          hit, rom_ok_w;
  logic [15:0]   word_addr;
  logic          unused_addr_lsb;

  assign word_addr       = bus.rom_addr[16:1];
  assign unused_addr_lsb = bus.rom_addr[0];
  assign rom_ok_w        = bus.rom_cs & hit & (state_q == IDLE);
  assign bus.rom_ok      = rom_ok_w;
  assign bus.sdram_req   = req_q;
  assign bus.sdram_addr  = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.rom_cs && !hit) state_d = REQ;
      REQ:     if (bus.sdram_ack) state_d = bus.sdram_dok ? BEAT1 : BEAT0;
      BEAT0:   if (bus.sdram_dok) state_d = BEAT1;
      BEAT1:   if (bus.sdram_dok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d      = req_q;
    addr_d     = addr_q;
    pend_d     = pend_q;
    start_fill = 1'b0;
    lo_we      = 1'b0;
    hi_we      = 1'b0;
    case (state_q)
      IDLE: if (bus.rom_cs && !hit) begin
        pend_d     = word_addr;
        addr_d     = OFFSET + AW'({word_addr, 1'b0});
        req_d      = 1'b1;
        start_fill = 1'b1;
      end
      REQ: if (bus.sdram_ack) begin
        req_d = 1'b0;
        lo_we = bus.sdram_dok;  // dok on the ack cycle is beat 0
      end
      BEAT0:   lo_we = bus.sdram_dok;
      BEAT1:   hi_we = bus.sdram_dok;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q  <= 1'b0;
      addr_q <= '0;
      pend_q <= '0;
    end else begin
      req_q  <= req_d;
      addr_q <= addr_d;
      pend_q <= pend_d;
    end
  end

`ifdef JTKUNIO_ROMSLOT_2WAY_EN
  logic [15:0] tag0_q, tag0_d, tag1_q, tag1_d;
  logic [31:0] data0_q, data0_d, data1_q, data1_d;
  logic        valid0_q, valid0_d, valid1_q, valid1_d;
  logic        lru_q, lru_d, way_q, way_d;
  logic        hit0, hit1;

  assign hit0         = valid0_q & (tag0_q == word_addr);
  assign hit1         = valid1_q & (tag1_q == word_addr);
  assign hit          = hit0 | hit1;
  assign bus.rom_data = hit1 ? data1_q : data0_q;

  // lru_q names the entry to replace next
  always_comb begin
    tag0_d   = tag0_q;
    tag1_d   = tag1_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    lru_d    = lru_q;
    way_d    = way_q;
    if (rom_ok_w) lru_d = hit0;
    if (start_fill) begin
      way_d = lru_q;
      if (lru_q) valid1_d = 1'b0;
      else       valid0_d = 1'b0;
    end
    if (lo_we) begin
      if (way_q) data1_d[15:0] = bus.sdram_din;
      else       data0_d[15:0] = bus.sdram_din;
    end
    if (hi_we) begin
      lru_d = ~way_q;
      if (way_q) begin
        data1_d[31:16] = bus.sdram_din;
        tag1_d         = pend_q;
        valid1_d       = 1'b1;
      end else begin
        data0_d[31:16] = bus.sdram_din;
        tag0_d         = pend_q;
        valid0_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag0_q   <= '0;
      tag1_q   <= '0;
      data0_q  <= '0;
      data1_q  <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      lru_q    <= 1'b0;
      way_q    <= 1'b0;
    end else begin
      tag0_q   <= tag0_d;
      tag1_q   <= tag1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      lru_q    <= lru_d;
      way_q    <= way_d;
    end
  end
`else
  logic [15:0] tag_q, tag_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;

  assign hit          = valid_q & (tag_q == word_addr);
  assign bus.rom_data = data_q;

  // valid drops at burst start so partial data never hits
  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (start_fill) valid_d = 1'b0;
    if (lo_we) data_d[15:0] = bus.sdram_din;
    if (hi_we) begin
      data_d[31:16] = bus.sdram_din;
      tag_d         = pend_q;
      valid_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
`endif
endmodule
